// File: rtl/alu_nibble_seq.sv
// Nibble-serial 8-bit ALU sequencer: one op per request handshake, evaluated
// low nibble then high nibble with the inter-nibble carry latched in between.
// Result and {Z,N,H,C} are presented in DONE until the consumer takes them.
module alu_nibble_seq (
    input  logic       clk,
    input  logic       nreset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [3:0] req_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic       rsp_wb
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t     state, state_next;
    logic [2:0] op;
    logic [7:0] a, b;
    logic       cin;
    logic       hc;
    logic [7:0] result;
    logic [3:0] flags;
    logic       wb;

    logic       is_sub, is_logic;
    logic [3:0] nib_a, nib_b, nib_b_eff, logic_res, nib_res;
    logic       carry_in;
    logic [4:0] sum;
    logic [7:0] full_res;
    logic       flag_z, flag_n, flag_h, flag_c;

    // Only the carry bit of the incoming flags feeds the datapath.
    logic unused_flags;
    assign unused_flags = ^req_flags[3:1];

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == DONE);
    assign rsp_result = result;
    assign rsp_flags  = flags;
    assign rsp_wb     = wb;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state: fixed walk IDLE -> LO -> HI -> DONE, back on response accept.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = LO;
            LO:      state_next = HI;
            HI:      state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One shared 4-bit adder/logic unit; the state picks which nibble and carry.
    // Subtraction is a + ~b + !cin, so the raw carry out is an inverted borrow.
    always_comb begin
        is_sub    = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
        is_logic  = (op == OP_AND) || (op == OP_XOR) || (op == OP_OR);
        nib_a     = (state == HI) ? a[7:4] : a[3:0];
        nib_b     = (state == HI) ? b[7:4] : b[3:0];
        nib_b_eff = is_sub ? ~nib_b : nib_b;
        carry_in  = (state == HI) ? hc : (is_sub ? ~cin : cin);
        sum       = {1'b0, nib_a} + {1'b0, nib_b_eff} + {4'b0000, carry_in};
        case (op)
            OP_AND:  logic_res = nib_a & nib_b;
            OP_XOR:  logic_res = nib_a ^ nib_b;
            default: logic_res = nib_a | nib_b;
        endcase
        nib_res  = is_logic ? logic_res : sum[3:0];
        full_res = {nib_res, result[3:0]};
        flag_z   = (full_res == 8'h00);
        flag_n   = is_sub;
        flag_h   = is_logic ? (op == OP_AND) : (is_sub ? ~hc : hc);
        flag_c   = is_logic ? 1'b0 : (is_sub ? ~sum[4] : sum[4]);
    end

    // Operand latch on accept, then low-nibble and high-nibble/flag passes.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            op     <= OP_ADD;
            a      <= 8'h00;
            b      <= 8'h00;
            cin    <= 1'b0;
            hc     <= 1'b0;
            result <= 8'h00;
            flags  <= 4'h0;
            wb     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op  <= req_op;
                    a   <= req_a;
                    b   <= req_b;
                    cin <= ((req_op == OP_ADC) || (req_op == OP_SBC)) & req_flags[0];
                end
                LO: begin
                    result[3:0] <= nib_res;
                    hc          <= sum[4];
                end
                HI: begin
                    result[7:4] <= nib_res;
                    flags       <= {flag_z, flag_n, flag_h, flag_c};
                    wb          <= (op != OP_CP);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq: expected responses are queued when a
// request is driven and compared when the response handshake comes around.
module tb_alu_nibble_seq;
    logic       clk = 1'b0;
    logic       nreset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a, req_b;
    logic [3:0] req_flags;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags;
    logic       rsp_wb;

    localparam logic [2:0] ADD = 3'd0, ADC = 3'd1, SUB = 3'd2, SBC = 3'd3;
    localparam logic [2:0] AND = 3'd4, XOR = 3'd5, OR  = 3'd6, CP  = 3'd7;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] fl;
        logic       wb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_nibble_seq dut (
        .clk        (clk),
        .nreset     (nreset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_flags  (req_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_wb     (rsp_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive one request and wait (bounded) for its accept edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] f, input bit push,
                        input logic [7:0] er, input logic [3:0] ef, input logic ew);
        int n;
        @(negedge clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_flags = f;
        req_valid = 1'b1;
        if (push) sb.push_back('{res: er, fl: ef, wb: ew});
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 8'(req_ready), 8'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after accept: the block must have latched its copy.
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        req_flags = 4'($urandom);
    endtask

    // Wait for a response, hold it off for 'hold' cycles, compare, then take it.
    task automatic receive(input int hold, input bit chk_lat);
        int   lat;
        exp_t e;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        chk("rsp_valid", 8'(rsp_valid), 8'd1);
        if (chk_lat) chk("latency", 8'(lat), 8'd3);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard: got empty queue expected pending entry");
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid",  8'(rsp_valid),  8'd1);
            chk("hold_ready",  8'(req_ready),  8'd0);
            chk("hold_result", rsp_result,     e.res);
            chk("hold_flags",  8'(rsp_flags),  8'(e.fl));
            @(negedge clk);
        end
        chk("result", rsp_result,    e.res);
        chk("flags",  8'(rsp_flags), 8'(e.fl));
        chk("wb",     8'(rsp_wb),    8'(e.wb));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        nreset    = 1'b0;
        req_valid = 1'b0;
        req_op    = ADD;
        req_a     = 8'h00;
        req_b     = 8'h00;
        req_flags = 4'h0;
        rsp_ready = 1'b0;
        #12;
        chk("rst_req_ready", 8'(req_ready), 8'd1);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_result",    rsp_result,    8'h00);
        chk("rst_flags",     8'(rsp_flags), 8'h0);
        chk("rst_wb",        8'(rsp_wb),    8'd0);
        @(negedge clk);
        nreset = 1'b1;

        // Arithmetic cases ({Z,N,H,C} expected flags)
        send(SUB, 8'h3E, 8'h0F, 4'h0, 1'b1, 8'h2F, 4'b0110, 1'b1); receive(0, 1'b1);
        send(ADD, 8'h3A, 8'hC6, 4'h0, 1'b1, 8'h00, 4'b1011, 1'b1); receive(0, 1'b1);
        send(ADC, 8'h0F, 8'h00, 4'h1, 1'b1, 8'h10, 4'b0010, 1'b1); receive(0, 1'b1);
        send(SBC, 8'h00, 8'h00, 4'h1, 1'b1, 8'hFF, 4'b0111, 1'b1); receive(0, 1'b1);
        send(SBC, 8'h00, 8'h00, 4'h0, 1'b1, 8'h00, 4'b1100, 1'b1); receive(0, 1'b1);
        send(CP,  8'h42, 8'h42, 4'h0, 1'b1, 8'h00, 4'b1100, 1'b0); receive(0, 1'b1);
        send(CP,  8'h10, 8'h20, 4'h0, 1'b1, 8'hF0, 4'b0101, 1'b0); receive(0, 1'b1);
        // Carry-in must be ignored for plain ADD/SUB
        send(ADD, 8'h01, 8'h01, 4'hF, 1'b1, 8'h02, 4'b0000, 1'b1); receive(0, 1'b1);
        send(SUB, 8'h05, 8'h03, 4'hF, 1'b1, 8'h02, 4'b0100, 1'b1); receive(0, 1'b1);
        send(XOR, 8'hFF, 8'h0F, 4'h0, 1'b1, 8'hF0, 4'b0000, 1'b1); receive(0, 1'b1);

        // Back-pressure with a second request waiting behind it
        send(AND, 8'h5A, 8'hA5, 4'h0, 1'b1, 8'h00, 4'b1010, 1'b1);
        req_op    = OR;
        req_a     = 8'h50;
        req_b     = 8'h05;
        req_flags = 4'hF;
        req_valid = 1'b1;
        sb.push_back('{res: 8'h55, fl: 4'b0000, wb: 1'b1});
        receive(3, 1'b1);
        @(negedge clk);
        chk("post_hs_ready", 8'(req_ready), 8'd1);
        chk("post_hs_valid", 8'(rsp_valid), 8'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        receive(0, 1'b1);

        // Reset during HI aborts the op without a response
        send(ADD, 8'hFF, 8'h01, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("abort_rsp_valid", 8'(rsp_valid),  8'd0);
        chk("abort_req_ready", 8'(req_ready),  8'd1);
        chk("abort_result",    rsp_result,     8'h00);
        chk("abort_flags",     8'(rsp_flags),  8'h0);
        chk("abort_wb",        8'(rsp_wb),     8'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_hold_valid", 8'(rsp_valid), 8'd0);
        end
        nreset = 1'b1;
        send(ADD, 8'h01, 8'h01, 4'h0, 1'b1, 8'h02, 4'b0000, 1'b1); receive(0, 1'b1);

        repeat (3) begin
            @(negedge clk);
            chk("idle_no_rsp", 8'(rsp_valid), 8'd0);
        end
        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
